// File: rtl/exmem_pipe_stage.sv
//------------------------------------------------------------------------------
// Module      : exmem_pipe_stage
// Description : EX->MEM pipeline register with valid/ready handshake,
//               DEPTH-deep elastic buffering with bubble collapse and flush.
//               Bubbles never present asserted control bits to MEM.
//               Optional feature macro: EXMEM_PERF_EN (stall/flush counters).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module exmem_pipe_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 5,
  parameter int DEPTH  = 2
`ifdef EXMEM_PERF_EN
  ,
  parameter int PERF_CNT_W = 32
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_zero,
  input  logic [DATA_W-1:0] in_alures,
  input  logic [DATA_W-1:0] in_b,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef EXMEM_PERF_EN
  output logic [PERF_CNT_W-1:0] perf_stall_cnt,
  output logic [PERF_CNT_W-1:0] perf_flush_cnt,
`endif
  output logic              out_zero,
  output logic [DATA_W-1:0] out_alures,
  output logic [DATA_W-1:0] out_b,
  output logic [REG_AW-1:0] out_rd,
  output logic [CTRL_W-1:0] out_ctrl
);

  // Slot state; slot DEPTH-1 is the one presented to MEM.
  logic [DEPTH-1:0]             valid_q,  valid_d;
  logic [DEPTH-1:0]             zero_q,   zero_d;
  logic [DEPTH-1:0][DATA_W-1:0] alures_q, alures_d;
  logic [DEPTH-1:0][DATA_W-1:0] b_q,      b_d;
  logic [DEPTH-1:0][REG_AW-1:0] rd_q,     rd_d;
  logic [DEPTH-1:0][CTRL_W-1:0] ctrl_q,   ctrl_d;

  // w_load[k]: slot k takes a new value (from k-1, or from the input for k=0)
  logic [DEPTH-1:0]             w_load;

  // Load chain: a slot may load when it is empty or its occupant moves on,
  // which folds to "out_ready, or any empty slot at or after this one".
  // Depends only on valid bits and out_ready, never on in_valid.
  always_comb begin : p_load_chain
    logic acc;
    acc = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      acc       = acc | ~valid_q[k];
      w_load[k] = acc;
    end
  end

  assign in_ready = w_load[0];

  // Next-state: shift entries forward into loading slots; flush overrides.
  always_comb begin : p_next_state
    valid_d  = valid_q;
    zero_d   = zero_q;
    alures_d = alures_q;
    b_d      = b_q;
    rd_d     = rd_q;
    ctrl_d   = ctrl_q;

    // Slot 0 is fed from the EX inputs.
    if (w_load[0]) begin
      valid_d[0] = in_valid;
      ctrl_d[0]  = in_valid ? in_ctrl : '0;
      if (in_valid) begin
        zero_d[0]   = in_zero;
        alures_d[0] = in_alures;
        b_d[0]      = in_b;
        rd_d[0]     = in_rd;
      end
    end

    // Remaining slots take the previous slot; an empty source clears ctrl
    // and leaves the rest of the payload untouched.
    for (int k = 1; k < DEPTH; k++) begin
      if (w_load[k]) begin
        valid_d[k] = valid_q[k-1];
        ctrl_d[k]  = valid_q[k-1] ? ctrl_q[k-1] : '0;
        if (valid_q[k-1]) begin
          zero_d[k]   = zero_q[k-1];
          alures_d[k] = alures_q[k-1];
          b_d[k]      = b_q[k-1];
          rd_d[k]     = rd_q[k-1];
        end
      end
    end

    // Flush drops everything held plus any same-cycle input.
    if (flush) begin
      valid_d = '0;
      ctrl_d  = '0;
    end
  end

  // Slot registers with synchronous reset clearing valid and payload.
  always_ff @(posedge clk) begin : p_slots
    if (rst) begin
      valid_q  <= '0;
      zero_q   <= '0;
      alures_q <= '0;
      b_q      <= '0;
      rd_q     <= '0;
      ctrl_q   <= '0;
    end else begin
      valid_q  <= valid_d;
      zero_q   <= zero_d;
      alures_q <= alures_d;
      b_q      <= b_d;
      rd_q     <= rd_d;
      ctrl_q   <= ctrl_d;
    end
  end

  assign out_valid  = valid_q[DEPTH-1];
  assign out_zero   = zero_q[DEPTH-1];
  assign out_alures = alures_q[DEPTH-1];
  assign out_b      = b_q[DEPTH-1];
  assign out_rd     = rd_q[DEPTH-1];
  // Control is masked by valid so a bubble can never write memory or regs.
  assign out_ctrl   = ctrl_q[DEPTH-1] & {CTRL_W{valid_q[DEPTH-1]}};

`ifdef EXMEM_PERF_EN
  logic [PERF_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [PERF_CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  // Saturating increments for stall (held output) and flush cycles.
  always_comb begin : p_perf_next
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (valid_q[DEPTH-1] && !out_ready && (stall_cnt_q != {PERF_CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (flush && (flush_cnt_q != {PERF_CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  // Counter registers, cleared only by reset.
  always_ff @(posedge clk) begin : p_perf_regs
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_exmem_pipe_stage.sv
//------------------------------------------------------------------------------
// Module      : tb_exmem_pipe_stage
// Description : Self-checking bench for exmem_pipe_stage (DEPTH=2).
//               Table of per-cycle vectors plus hand-written reset/perf runs.
//               Perf checks are built when EXMEM_PERF_EN is defined.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_exmem_pipe_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic        in_zero;
  logic [31:0] in_alures;
  logic [31:0] in_b;
  logic [4:0]  in_rd;
  logic [4:0]  in_ctrl;
  logic        out_valid;
  logic        out_ready;
  logic        out_zero;
  logic [31:0] out_alures;
  logic [31:0] out_b;
  logic [4:0]  out_rd;
  logic [4:0]  out_ctrl;
`ifdef EXMEM_PERF_EN
  logic [3:0]  perf_stall_cnt;
  logic [3:0]  perf_flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exmem_pipe_stage #(
    .DATA_W (32),
    .REG_AW (5),
    .CTRL_W (5),
    .DEPTH  (2)
`ifdef EXMEM_PERF_EN
    ,
    .PERF_CNT_W (4)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_zero    (in_zero),
    .in_alures  (in_alures),
    .in_b       (in_b),
    .in_rd      (in_rd),
    .in_ctrl    (in_ctrl),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
`ifdef EXMEM_PERF_EN
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt),
`endif
    .out_zero   (out_zero),
    .out_alures (out_alures),
    .out_b      (out_b),
    .out_rd     (out_rd),
    .out_ctrl   (out_ctrl)
  );

  typedef struct {
    logic        fl;
    logic        iv;
    logic        ord;
    logic [31:0] alu;
    logic [4:0]  ctrl;
    logic        e_ov;
    logic        e_ir;
    logic [31:0] e_alu;
    logic [4:0]  e_ctrl;
  } vec_t;

  localparam int NVEC = 28;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic fl, input logic iv, input logic ord,
                              input logic [31:0] alu, input logic [4:0] ctrl,
                              input logic e_ov, input logic e_ir,
                              input logic [31:0] e_alu, input logic [4:0] e_ctrl);
    vec_t v;
    v.fl = fl; v.iv = iv; v.ord = ord; v.alu = alu; v.ctrl = ctrl;
    v.e_ov = e_ov; v.e_ir = e_ir; v.e_alu = e_alu; v.e_ctrl = e_ctrl;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Payload fields are derived from the ALU value so one number names an entry.
  task automatic drive(input logic fl, input logic iv, input logic ord,
                       input logic [31:0] alu, input logic [4:0] ctrl);
    flush     = fl;
    in_valid  = iv;
    out_ready = ord;
    in_alures = alu;
    in_b      = ~alu;
    in_rd     = alu[4:0];
    in_zero   = alu[0];
    in_ctrl   = ctrl;
  endtask

  initial begin
    // Stream, backpressure, bubble collapse and flush, one row per cycle.
    vecs[0]  = mk(0, 1, 1, 32'd1,  5'h10, 0, 1, 32'd0,  5'h00);
    vecs[1]  = mk(0, 1, 1, 32'd2,  5'h10, 0, 1, 32'd0,  5'h00);
    vecs[2]  = mk(0, 1, 1, 32'd3,  5'h10, 1, 1, 32'd1,  5'h10);
    vecs[3]  = mk(0, 1, 1, 32'd4,  5'h10, 1, 1, 32'd2,  5'h10);
    vecs[4]  = mk(0, 0, 1, 32'd0,  5'h00, 1, 1, 32'd3,  5'h10);
    vecs[5]  = mk(0, 0, 1, 32'd0,  5'h00, 1, 1, 32'd4,  5'h10);
    vecs[6]  = mk(0, 0, 1, 32'd0,  5'h00, 0, 1, 32'd0,  5'h00);
    vecs[7]  = mk(0, 1, 0, 32'd5,  5'h0A, 0, 1, 32'd0,  5'h00);
    vecs[8]  = mk(0, 1, 0, 32'd6,  5'h0A, 0, 1, 32'd0,  5'h00);
    vecs[9]  = mk(0, 1, 0, 32'd7,  5'h0A, 1, 0, 32'd5,  5'h0A);
    vecs[10] = mk(0, 1, 0, 32'd7,  5'h0A, 1, 0, 32'd5,  5'h0A);
    vecs[11] = mk(0, 1, 1, 32'd7,  5'h0A, 1, 1, 32'd5,  5'h0A);
    vecs[12] = mk(0, 0, 1, 32'd0,  5'h00, 1, 1, 32'd6,  5'h0A);
    vecs[13] = mk(0, 0, 1, 32'd0,  5'h00, 1, 1, 32'd7,  5'h0A);
    vecs[14] = mk(0, 0, 0, 32'd0,  5'h00, 0, 1, 32'd0,  5'h00);
    vecs[15] = mk(0, 1, 0, 32'd39, 5'h1F, 0, 1, 32'd0,  5'h00);
    vecs[16] = mk(0, 0, 0, 32'd0,  5'h00, 0, 1, 32'd0,  5'h00);
    vecs[17] = mk(0, 0, 0, 32'd0,  5'h00, 1, 1, 32'd39, 5'h1F);
    vecs[18] = mk(0, 1, 0, 32'd40, 5'h1F, 1, 1, 32'd39, 5'h1F);
    vecs[19] = mk(0, 1, 0, 32'd41, 5'h1F, 1, 0, 32'd39, 5'h1F);
    vecs[20] = mk(0, 0, 1, 32'd0,  5'h00, 1, 1, 32'd39, 5'h1F);
    vecs[21] = mk(0, 1, 0, 32'd42, 5'h08, 1, 1, 32'd40, 5'h1F);
    vecs[22] = mk(1, 1, 0, 32'd43, 5'h08, 1, 0, 32'd40, 5'h1F);
    vecs[23] = mk(0, 0, 0, 32'd0,  5'h00, 0, 1, 32'd0,  5'h00);
    vecs[24] = mk(0, 0, 1, 32'd0,  5'h00, 0, 1, 32'd0,  5'h00);
    vecs[25] = mk(0, 1, 0, 32'd44, 5'h08, 0, 1, 32'd0,  5'h00);
    vecs[26] = mk(1, 1, 0, 32'd45, 5'h08, 0, 1, 32'd0,  5'h00);
    vecs[27] = mk(0, 0, 1, 32'd0,  5'h00, 0, 1, 32'd0,  5'h00);

    // Reset held two cycles with input offered; nothing may be captured.
    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 32'd99, 5'h1F);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 5'h00);
    #1;
    chk("reset out_valid",  {31'd0, out_valid}, 32'd0);
    chk("reset out_ctrl",   {27'd0, out_ctrl},  32'd0);
    chk("reset in_ready",   {31'd0, in_ready},  32'd1);
    chk("reset out_alures", out_alures,         32'd0);
    chk("reset out_rd",     {27'd0, out_rd},    32'd0);

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      drive(vecs[i].fl, vecs[i].iv, vecs[i].ord, vecs[i].alu, vecs[i].ctrl);
      #1;
      chk($sformatf("vec%0d out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_ov});
      chk($sformatf("vec%0d in_ready", i),  {31'd0, in_ready},  {31'd0, vecs[i].e_ir});
      chk($sformatf("vec%0d out_ctrl", i),  {27'd0, out_ctrl},  {27'd0, vecs[i].e_ctrl});
      if (vecs[i].e_ov) begin
        chk($sformatf("vec%0d out_alures", i), out_alures, vecs[i].e_alu);
        chk($sformatf("vec%0d out_rd", i),   {27'd0, out_rd},   {27'd0, vecs[i].e_alu[4:0]});
        chk($sformatf("vec%0d out_b", i),    out_b,             ~vecs[i].e_alu);
        chk($sformatf("vec%0d out_zero", i), {31'd0, out_zero}, {31'd0, vecs[i].e_alu[0]});
      end
    end

    // Reset in the middle of a stream discards the held entries.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 32'd50, 5'h18);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 32'd51, 5'h18);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 5'h00);
    #1;
    chk("midrst pre out_valid",  {31'd0, out_valid}, 32'd1);
    chk("midrst pre out_alures", out_alures,         32'd50);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst out_ctrl",  {27'd0, out_ctrl},  32'd0);
    chk("midrst in_ready",  {31'd0, in_ready},  32'd1);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 32'd0, 5'h00);
    #1;
    chk("midrst later out_valid", {31'd0, out_valid}, 32'd0);

`ifdef EXMEM_PERF_EN
    // Counters: 20+ stall cycles saturate at 15, 3 flush cycles count 3.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 5'h00);
    #1;
    chk("perf reset stall", {28'd0, perf_stall_cnt}, 32'd0);
    chk("perf reset flush", {28'd0, perf_flush_cnt}, 32'd0);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 32'd60, 5'h10);
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 32'd0, 5'h00);
    end
    #1;
    chk("perf stall sat", {28'd0, perf_stall_cnt}, 32'd15);
    chk("perf flush idle", {28'd0, perf_flush_cnt}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, 1'b0, 32'd0, 5'h00);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 5'h00);
    #1;
    chk("perf flush cnt", {28'd0, perf_flush_cnt}, 32'd3);
    chk("perf stall held", {28'd0, perf_stall_cnt}, 32'd15);
`endif

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
